// File: rtl/sift_det_pkg.sv
// sift_det_pkg: shared encodings and constants for the DoG extremum detection path
package sift_det_pkg;

   typedef enum logic [1:0] {
      MODE_OFF  = 2'b00,
      MODE_MIN  = 2'b01,
      MODE_MAX  = 2'b10,
      MODE_BOTH = 2'b11
   } mode_e;

   localparam int DET_LAT = 3;
   localparam int RED_GRP = 8;

   typedef struct packed {
      logic       valid;
      logic       sof;
      logic       eof;
      logic [1:0] mode;
   } side_t;

endpackage

// File: rtl/nb_compare_tree.sv
// nb_compare_tree: per-neighbour centre compare (stage 1) and grouped AND-reduce (stage 2)
module nb_compare_tree
   import sift_det_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NUM_NB = 26,
   parameter int NUM_GRP = (NUM_NB + RED_GRP - 1) / RED_GRP
) (
   input  logic                     iclk,
   input  logic                     irst_n,
   input  logic [DATA_W-1:0]        iCenter,
   input  logic [NUM_NB*DATA_W-1:0] iNeigh,
   input  logic                     iStrict,
   output logic [NUM_GRP-1:0]       oLePart,
   output logic [NUM_GRP-1:0]       oGePart
);

   logic [NUM_NB-1:0]          leNext, geNext, le, ge;
   logic [NUM_GRP*RED_GRP-1:0] lePad, gePad;

   for (genvar k = 0; k < NUM_NB; k++) begin : g_cmp
      logic signed [DATA_W-1:0] nb;
      logic                     tie;
      assign nb        = iNeigh[k*DATA_W +: DATA_W];
      assign tie       = (iCenter == nb) && !iStrict;
      assign leNext[k] = ($signed(iCenter) < nb) || tie;
      assign geNext[k] = ($signed(iCenter) > nb) || tie;
   end

   // Unused slots of the last group read as 1 so they never veto the reduction
   always_comb begin
      lePad = '1;
      gePad = '1;
      lePad[NUM_NB-1:0] = le;
      gePad[NUM_NB-1:0] = ge;
   end

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         le      <= '0;
         ge      <= '0;
         oLePart <= '0;
         oGePart <= '0;
      end else begin
         le <= leNext;
         ge <= geNext;
         for (int g = 0; g < NUM_GRP; g++) begin
            oLePart[g] <= &lePad[g*RED_GRP +: RED_GRP];
            oGePart[g] <= &gePad[g*RED_GRP +: RED_GRP];
         end
      end
   end

endmodule

// File: rtl/dog_extremum_detector.sv
// dog_extremum_detector: streaming DoG local min/max qualifier with contrast gate
// and per-frame keypoint counter, fixed 3-cycle latency
module dog_extremum_detector
   import sift_det_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NUM_NB = 26,
   parameter int CNT_W  = 16
) (
   input  logic                     iclk,
   input  logic                     irst_n,
   input  logic                     iValid,
   input  logic                     iSof,
   input  logic                     iEof,
   input  logic [DATA_W-1:0]        iCenter,
   input  logic [NUM_NB*DATA_W-1:0] iNeigh,
   input  logic [1:0]               iMode,
   input  logic                     iStrict,
   input  logic [DATA_W-1:0]        iThresh,
   output logic                     oValid,
   output logic                     oIsMin,
   output logic                     oIsMax,
   output logic                     oKey,
   output logic [CNT_W-1:0]         oFrameCount,
   output logic                     oFrameDone,
   output logic                     oSat
);

   localparam int NUM_GRP = (NUM_NB + RED_GRP - 1) / RED_GRP;
   localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

   side_t              side1, side2;
   logic [DATA_W-1:0]  absC, abs1, abs2, thr1, thr2;
   logic [NUM_GRP-1:0] lePart, gePart;
   logic               contrastOk, wantMin, wantMax, candMin, candMax;
   logic               isMin, isMax, key, clamp;
   logic [CNT_W-1:0]   runCnt, baseCnt, updCnt;
   logic               runSat, baseSat, updSat;

   nb_compare_tree #(
      .DATA_W (DATA_W),
      .NUM_NB (NUM_NB)
   ) uTree (
      .iclk    (iclk),
      .irst_n  (irst_n),
      .iCenter (iCenter),
      .iNeigh  (iNeigh),
      .iStrict (iStrict),
      .oLePart (lePart),
      .oGePart (gePart)
   );

   // The most negative sample has no positive twin, so it clamps to the largest magnitude
   assign absC = (iCenter == MOST_NEG) ? ~MOST_NEG : iCenter[DATA_W-1] ? -iCenter : iCenter;

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         side1 <= '0;
         side2 <= '0;
         abs1  <= '0;
         abs2  <= '0;
         thr1  <= '0;
         thr2  <= '0;
      end else begin
         side1 <= side_t'{iValid, iSof, iEof, iMode};
         abs1  <= absC;
         thr1  <= iThresh;
         side2 <= side1;
         abs2  <= abs1;
         thr2  <= thr1;
      end
   end

   assign contrastOk = abs2 > thr2;
   assign wantMin    = (side2.mode == MODE_MIN) || (side2.mode == MODE_BOTH);
   assign wantMax    = (side2.mode == MODE_MAX) || (side2.mode == MODE_BOTH);
   assign candMin    = side2.valid && (&lePart) && wantMin && contrastOk;
   assign candMax    = side2.valid && (&gePart) && wantMax && contrastOk;
   // A centre that is both a min and a max sits in a flat region and is not a keypoint
   assign isMin      = candMin && !candMax;
   assign isMax      = candMax && !candMin;
   assign key        = isMin || isMax;

   assign baseCnt = side2.sof ? '0 : runCnt;
   assign baseSat = side2.sof ? 1'b0 : runSat;
   assign clamp   = key && (&baseCnt);
   assign updCnt  = baseCnt + CNT_W'(key && !clamp);
   assign updSat  = baseSat || clamp;

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         oValid      <= 1'b0;
         oIsMin      <= 1'b0;
         oIsMax      <= 1'b0;
         oKey        <= 1'b0;
         oFrameDone  <= 1'b0;
         oFrameCount <= '0;
         oSat        <= 1'b0;
         runCnt      <= '0;
         runSat      <= 1'b0;
      end else begin
         oValid     <= side2.valid;
         oIsMin     <= isMin;
         oIsMax     <= isMax;
         oKey       <= key;
         oFrameDone <= side2.valid && side2.eof;
         if (side2.valid) begin
            runCnt <= side2.eof ? '0 : updCnt;
            runSat <= side2.eof ? 1'b0 : updSat;
            if (side2.eof) begin
               oFrameCount <= updCnt;
               oSat        <= updSat;
            end
         end
      end
   end

endmodule

// File: tb/tb_dog_extremum_detector.sv
// tb_dog_extremum_detector: directed vectors with a queue scoreboard and a decoupled monitor
module tb_dog_extremum_detector;
   import sift_det_pkg::*;

   localparam int DW = 8;
   localparam int NB = 26;
   localparam int CW = 4;

   logic              iclk = 1'b0;
   logic              irst_n = 1'b0;
   logic              iValid = 1'b0, iSof = 1'b0, iEof = 1'b0, iStrict = 1'b0;
   logic [DW-1:0]     iCenter = '0, iThresh = '0;
   logic [NB*DW-1:0]  iNeigh = '0;
   logic [1:0]        iMode = '0;
   logic              oValid, oIsMin, oIsMax, oKey, oFrameDone, oSat;
   logic [CW-1:0]     oFrameCount;

   dog_extremum_detector #(.DATA_W(DW), .NUM_NB(NB), .CNT_W(CW)) dut (
      .iclk        (iclk),
      .irst_n      (irst_n),
      .iValid      (iValid),
      .iSof        (iSof),
      .iEof        (iEof),
      .iCenter     (iCenter),
      .iNeigh      (iNeigh),
      .iMode       (iMode),
      .iStrict     (iStrict),
      .iThresh     (iThresh),
      .oValid      (oValid),
      .oIsMin      (oIsMin),
      .oIsMax      (oIsMax),
      .oKey        (oKey),
      .oFrameCount (oFrameCount),
      .oFrameDone  (oFrameDone),
      .oSat        (oSat)
   );

   always #5 iclk = ~iclk;

   int cyc = 0;
   always @(posedge iclk) cyc++;

   typedef struct {
      int cyc;
      bit mn;
      bit mx;
      bit done;
      int cnt;
      bit sat;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0d want %0d (cycle %0d)", n, got, want, cyc);
      end
   endtask

   task automatic beat(input bit v, input bit s, input bit e, input int c, input int nbv,
                       input int nbl, input int m, input bit st, input int th,
                       input bit xmn, input bit xmx, input int xcnt, input bit xsat);
      @(posedge iclk);
      #1;
      iValid  = v;
      iSof    = s;
      iEof    = e;
      iCenter = 8'(c);
      for (int k = 0; k < NB; k++) iNeigh[k*DW +: DW] = 8'((k == NB-1) ? nbl : nbv);
      iMode   = 2'(m);
      iStrict = st;
      iThresh = 8'(th);
      if (v) q.push_back(exp_t'{cyc, xmn, xmx, e, xcnt, xsat});
   endtask

   // Idle slots carry a would-be key with sof/eof set to prove they are ignored
   task automatic bubble();
      beat(0, 1, 1, -5, 3, 3, 3, 0, 2, 0, 0, 0, 0);
   endtask

   task automatic keyBeat(input bit s, input bit e, input int xcnt, input bit xsat);
      beat(1, s, e, -5, 3, 3, 3, 0, 2, 1, 0, xcnt, xsat);
   endtask

   task automatic plainBeat(input bit s, input bit e, input int xcnt, input bit xsat);
      beat(1, s, e, 0, 0, 0, 3, 0, 0, 0, 0, xcnt, xsat);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge iclk);
         if (!irst_n) begin
            chk("rst_valid", oValid, 0);
            chk("rst_flags", {oIsMin, oIsMax, oKey, oFrameDone, oSat}, 0);
            chk("rst_count", oFrameCount, 0);
         end else if (oValid) begin
            if (q.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
               e = q.pop_front();
               chk("latency", cyc - e.cyc, DET_LAT);
               chk("isMin", oIsMin, e.mn);
               chk("isMax", oIsMax, e.mx);
               chk("key", oKey, e.mn | e.mx);
               chk("frameDone", oFrameDone, e.done);
               if (e.done) begin
                  chk("frameCount", oFrameCount, e.cnt);
                  chk("sat", oSat, e.sat);
               end
            end
         end else chk("bubble_flags", {oIsMin, oIsMax, oKey, oFrameDone}, 0);
      end
   end

   initial begin
      repeat (2) @(posedge iclk);
      #1 irst_n = 1'b1;
      bubble();
      // basic min, one-beat frame
      beat(1, 1, 1, -5, 3, 3, 3, 0, 2, 1, 0, 1, 0);
      // flat region, back to back with changing mode/strict
      beat(1, 1, 1, 4, 4, 4, 3, 0, 0, 0, 0, 0, 0);
      beat(1, 1, 1, 4, 4, 4, 3, 1, 0, 0, 0, 0, 0);
      beat(1, 1, 1, 4, 4, 4, 1, 0, 0, 1, 0, 1, 0);
      // contrast gating at the most negative sample
      beat(1, 1, 1, -128, 0, 0, 1, 0, 126, 1, 0, 1, 0);
      beat(1, 1, 1, -128, 0, 0, 1, 0, 127, 0, 0, 0, 0);
      // last neighbour decides the max
      beat(1, 1, 1, 10, 0, 11, 2, 0, 0, 0, 0, 0, 0);
      beat(1, 1, 1, 10, 0, 10, 2, 0, 0, 0, 1, 1, 0);
      beat(1, 1, 1, 10, 0, 10, 2, 1, 0, 0, 0, 0, 0);
      beat(1, 1, 1, 10, 0, 10, 0, 0, 0, 0, 0, 0, 0);
      // 8-beat frame with bubbles, keys on beats 1, 4, 8
      for (int i = 1; i <= 8; i++) begin
         if (i == 1 || i == 4 || i == 8) keyBeat(i == 1, i == 8, 3, 0);
         else plainBeat(0, 0, 0, 0);
         bubble();
      end
      // reset in the middle of the next frame
      keyBeat(1, 0, 0, 0);
      keyBeat(0, 0, 0, 0);
      @(posedge iclk);
      #1 iValid = 1'b0;
      #2 irst_n = 1'b0;
      repeat (2) @(posedge iclk);
      q.delete();
      #1 irst_n = 1'b1;
      keyBeat(1, 0, 0, 0);
      plainBeat(0, 1, 1, 0);
      bubble();
      // saturation of the 4-bit counter
      for (int i = 0; i < 20; i++) keyBeat(i == 0, i == 19, 15, 1);
      keyBeat(1, 0, 0, 0);
      plainBeat(0, 0, 0, 0);
      keyBeat(0, 1, 2, 0);
      repeat (6) bubble();
      chk("drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
